// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time writer for the CPU instruction memory. Bytes arrive over a
//   valid/ready stream, least-significant byte first. Every group of four
//   bytes becomes one 32-bit word, written to consecutive word-aligned
//   addresses starting at 0. The CPU is held in reset until the requested
//   number of words has been written.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start, word_count     begin a load of word_count words (IDLE/DONE only)
//   byte_valid/byte_data  incoming byte stream
//   byte_ready            a byte can be accepted this cycle
//   imem_we/addr/wdata    instruction memory write port (one pulse per word)
//   cpu_reset             1 = hold the CPU in reset
//   busy, done, error     load status
module imem_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Memory depth in words; the largest count a load may request.
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state, state_next;
    logic [1:0]            byte_idx;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [ADDR_WIDTH:0]   word_idx_inc;
    logic [ADDR_WIDTH:0]   count;
    logic [TW-1:0]         timer;
    logic [23:0]           word_lo;   // bytes 0..2; byte 3 goes straight to imem_wdata
    logic                  accept;
    logic                  load_start;

    assign accept       = byte_valid && (state == S_RECV);
    assign word_idx_inc = word_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_reset  = 1'b1;
        imem_we    = 1'b0;
        load_start = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (state == S_DONE) begin
                    done      = 1'b1;
                    cpu_reset = 1'b0;
                end
                if (start) begin
                    if (word_count == '0) begin
                        state_next = S_DONE;
                    end else if (word_count > DEPTH) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_RECV;
                        load_start = 1'b1;
                    end
                end
            end
            S_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    if (byte_idx == 2'd3) begin
                        state_next = S_WRITE;
                    end
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    // This idle cycle brings the timer to TIMEOUT_CYCLES.
                    state_next = S_ERR;
                end
            end
            S_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                if (word_idx_inc == count) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_RECV;
                end
            end
            S_ERR: begin
                error = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx   <= '0;
            word_idx   <= '0;
            count      <= '0;
            timer      <= '0;
            word_lo    <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            if (load_start) begin
                byte_idx <= '0;
                word_idx <= '0;
                timer    <= '0;
                count    <= word_count;
            end
            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                timer    <= '0;
                case (byte_idx)
                    2'd0: word_lo[7:0]   <= byte_data;
                    2'd1: word_lo[15:8]  <= byte_data;
                    2'd2: word_lo[23:16] <= byte_data;
                    default: begin
                        // Last byte: present the whole word during WRITE and
                        // keep it (and its address) afterwards.
                        imem_wdata <= {byte_data, word_lo};
                        imem_addr  <= 32'({word_idx[ADDR_WIDTH-1:0], 2'b00});
                    end
                endcase
            end else if (state == S_RECV) begin
                timer <= timer + TW'(1);
            end
            if (state == S_WRITE) begin
                word_idx <= word_idx_inc;
            end
        end
    end

endmodule
